// File: rtl/fpga_cfg_pkg.sv
// Shared types and helpers for the fpga configuration loader.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package fpga_cfg_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ENABLE = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  // err_code encodings.
  localparam logic [1:0] ERR_NONE  = 2'd0;  // no error
  localparam logic [1:0] ERR_SHORT = 2'd1;  // cfg_last seen before the final frame
  localparam logic [1:0] ERR_LONG  = 2'd2;  // final frame arrived without cfg_last

  // Bits needed to hold values 0..max_val; never less than 1.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Largest of three delay values, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fpga_cfg_timer.sv
// Loadable down-counter with a one-cycle done pulse, shared by PRE/SETTLE/ENABLE.
// Latency: done_o is high during the N-th cycle after a load of value N (N >= 1).
// Backpressure: none; load_i always wins over counting.
//
// Ports:
//   clk_i      - clock
//   rst_i      - synchronous active-high reset, clears the count
//   load_i     - load load_val_i into the counter this edge
//   load_val_i - number of cycles to count
//   done_o     - high while the count is 1 (last cycle of the interval)
module fpga_cfg_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Count down to zero and park there; a load restarts the interval.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count value 1 marks the final cycle of the loaded interval.
  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams configuration frames into the fpga fabric, then enables flip-flops and reports ready.
// Latency: frame accepted at edge t is strobed on configs_en/configs_in during cycle t+1.
// Backpressure: cfg_ready_o is high only in LOAD; one frame per cycle while ready.
//
// Ports:
//   clock_i, rst_i          - clock and synchronous active-high reset
//   start_i                 - begin (re)configuration from IDLE, RUN or ERROR
//   cfg_data_i/_valid_i/_last_i, cfg_ready_o - frame stream (valid/ready)
//   configs_in_o, configs_en_o - frame data and one-hot frame write strobe to the fabric
//   ff_en_o, rdy_o          - fabric flip-flop enable, configuration complete
//   busy_o, err_o, err_code_o, frame_cnt_o - status
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int FRAME_W       = 224,
  parameter int NUM_FRAMES    = 245,
  parameter int PRE_CYCLES    = 10,
  parameter int SETTLE_CYCLES = 10,
  parameter int RDY_DELAY     = 10
) (
  input  logic                            clock_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [FRAME_W-1:0]              cfg_data_i,
  input  logic                            cfg_valid_i,
  input  logic                            cfg_last_i,
  output logic                            cfg_ready_o,
  output logic [FRAME_W-1:0]              configs_in_o,
  output logic [NUM_FRAMES-1:0]           configs_en_o,
  output logic                            ff_en_o,
  output logic                            rdy_o,
  output logic                            busy_o,
  output logic                            err_o,
  output logic [1:0]                      err_code_o,
  output logic [$clog2(NUM_FRAMES+1)-1:0] frame_cnt_o
);

  localparam int CW = $clog2(NUM_FRAMES + 1);
  localparam int TW = cnt_w(max3(PRE_CYCLES, SETTLE_CYCLES, RDY_DELAY));
  localparam logic [CW-1:0]         LAST_IDX = CW'(NUM_FRAMES - 1);
  localparam logic [NUM_FRAMES-1:0] EN_ONE   = NUM_FRAMES'(1);

  if (NUM_FRAMES < 2 || SETTLE_CYCLES < 1 || RDY_DELAY < 1 || PRE_CYCLES < 0) begin : g_param_chk
    $error("fpga_cfg_loader: illegal parameter combination");
  end

  state_e                 state_q, state_d;
  logic [CW-1:0]          frame_cnt_q, frame_cnt_d;
  logic [FRAME_W-1:0]     cfg_q, cfg_d;
  logic [NUM_FRAMES-1:0]  en_q, en_d;
  logic [1:0]             err_code_q, err_code_d;

  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic                   tmr_done;

  logic                   restart;
  logic                   accept;
  logic                   at_last_idx;

  // start is only honoured from the quiescent states; elsewhere it is dropped.
  assign restart     = start_i & (state_q inside {ST_IDLE, ST_RUN, ST_ERROR});
  assign accept      = cfg_valid_i & cfg_ready_o;
  assign at_last_idx = (frame_cnt_q == LAST_IDX);

  fpga_cfg_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (clock_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state + timer reload
  // The timer is loaded on the edge that enters a timed state, so its done
  // pulse lands in the last cycle of that state. SETTLE is entered on the
  // final accept, which makes the strobe cycle the first settle cycle.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start_i) begin
          if (PRE_CYCLES == 0) begin
            state_d = ST_LOAD;
          end else begin
            state_d  = ST_PRE;
            tmr_load = 1'b1;
            tmr_val  = TW'(PRE_CYCLES);
          end
        end
      end
      ST_PRE: begin
        if (tmr_done) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (at_last_idx) begin
            if (cfg_last_i) begin
              state_d  = ST_SETTLE;
              tmr_load = 1'b1;
              tmr_val  = TW'(SETTLE_CYCLES);
            end else begin
              state_d = ST_ERROR;
            end
          end else if (cfg_last_i) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          state_d  = ST_ENABLE;
          tmr_load = 1'b1;
          tmr_val  = TW'(RDY_DELAY);
        end
      end
      ST_ENABLE: begin
        if (tmr_done) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- outputs from state
  always_comb begin
    cfg_ready_o = (state_q == ST_LOAD);
    ff_en_o     = (state_q == ST_ENABLE) || (state_q == ST_RUN);
    rdy_o       = (state_q == ST_RUN);
    busy_o      = !(state_q inside {ST_IDLE, ST_RUN, ST_ERROR});
    // ERROR is only left through start or rst, so the state itself is the sticky flag.
    err_o       = (state_q == ST_ERROR);
  end

  // ---------------------------------------------------------------- frame datapath
  // A rejected frame (short or long) is still written to the fabric; only the
  // state transition differs. The strobe register defaults to zero so it is
  // high for exactly the one cycle after each accept.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_code_d  = err_code_q;
    cfg_d       = cfg_q;
    en_d        = '0;
    if (restart) begin
      frame_cnt_d = '0;
      err_code_d  = ERR_NONE;
    end
    if (accept) begin
      cfg_d       = cfg_data_i;
      en_d        = EN_ONE << frame_cnt_q;
      frame_cnt_d = frame_cnt_q + 1'b1;
      if (cfg_last_i && !at_last_idx) begin
        err_code_d = ERR_SHORT;
      end else if (!cfg_last_i && at_last_idx) begin
        err_code_d = ERR_LONG;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
      err_code_q  <= ERR_NONE;
      cfg_q       <= '0;
      en_q        <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_code_q  <= err_code_d;
      cfg_q       <= cfg_d;
      en_q        <= en_d;
    end
  end

  assign configs_in_o = cfg_q;
  assign configs_en_o = en_q;
  assign err_code_o   = err_code_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader with small parameters.
// Latency: checks strobe timing, settle and ready delays cycle-exactly.
// Backpressure: exercises throttled cfg_valid and frames offered outside LOAD.
module tb_fpga_cfg_loader;

  localparam int FW  = 8;
  localparam int NF  = 4;
  localparam int PRE = 2;
  localparam int SET = 3;
  localparam int RD  = 2;
  localparam int CW  = $clog2(NF + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [FW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_last;
  logic          cfg_ready;
  logic [FW-1:0] configs_in;
  logic [NF-1:0] configs_en;
  logic          ff_en;
  logic          rdy;
  logic          busy;
  logic          err;
  logic [1:0]    err_code;
  logic [CW-1:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [FW-1:0] frames [NF];

  fpga_cfg_loader #(
    .FRAME_W       (FW),
    .NUM_FRAMES    (NF),
    .PRE_CYCLES    (PRE),
    .SETTLE_CYCLES (SET),
    .RDY_DELAY     (RD)
  ) dut (
    .clock_i      (clk),
    .rst_i        (rst),
    .start_i      (start),
    .cfg_data_i   (cfg_data),
    .cfg_valid_i  (cfg_valid),
    .cfg_last_i   (cfg_last),
    .cfg_ready_o  (cfg_ready),
    .configs_in_o (configs_in),
    .configs_en_o (configs_en),
    .ff_en_o      (ff_en),
    .rdy_o        (rdy),
    .busy_o       (busy),
    .err_o        (err),
    .err_code_o   (err_code),
    .frame_cnt_o  (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_data  = '0;
  endtask

  // Full 4-frame load from a quiescent state, optionally with a gap cycle between frames.
  task automatic run_load(input bit throttle, input string tag);
    int            cyc;
    logic          en_seen;
    logic [NF-1:0] exp_en;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({ff_en, rdy, err, err_code, frame_cnt, busy} !== 9'b000000001) begin
      n_fail++;
      $display("FAIL %s start_cycle: ff_en,rdy,err,code,cnt,busy=%b expected 000000001",
               tag, {ff_en, rdy, err, err_code, frame_cnt, busy});
    end
    cyc = 0;
    while (cfg_ready !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != PRE || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_delay: cycles=%0d busy=%b expected %0d busy=1", tag, cyc, busy, PRE);
    end
    for (int i = 0; i < NF; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = frames[i];
      cfg_last  = (i == NF - 1);
      step();
      exp_en = 4'b0001 << i;
      n_checks++;
      if (configs_en !== exp_en || configs_in !== frames[i] || frame_cnt !== CW'(i + 1)) begin
        n_fail++;
        $display("FAIL %s strobe%0d: en=%b in=%h cnt=%0d expected en=%b in=%h cnt=%0d",
                 tag, i, configs_en, configs_in, frame_cnt, exp_en, frames[i], i + 1);
      end
      if (throttle && i < NF - 1) begin
        cfg_valid = 1'b0;
        cfg_data  = 8'hFF;
        cfg_last  = 1'b1;
        step();
        n_checks++;
        if (configs_en !== 4'b0000 || configs_in !== frames[i] || frame_cnt !== CW'(i + 1) ||
            cfg_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL %s gap%0d: en=%b in=%h cnt=%0d rdy=%b expected en=0000 in=%h cnt=%0d rdy=1",
                   tag, i, configs_en, configs_in, frame_cnt, cfg_ready, frames[i], i + 1);
        end
      end
    end
    idle_inputs();
    cyc     = 0;
    en_seen = 1'b0;
    while (ff_en !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
      if (configs_en !== 4'b0000) en_seen = 1'b1;
    end
    n_checks++;
    if (cyc != SET || en_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ff_en_delay: cycles=%0d stray_strobe=%b expected %0d and 0", tag, cyc, en_seen, SET);
    end
    cyc = 0;
    while (rdy !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != RD) begin
      n_fail++;
      $display("FAIL %s rdy_delay: cycles=%0d expected %0d", tag, cyc, RD);
    end
    n_checks++;
    if ({ff_en, rdy, busy, err, err_code, frame_cnt, configs_in, configs_en} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd4, 8'h44, 4'b0000}) begin
      n_fail++;
      $display("FAIL %s run_state: ff_en=%b rdy=%b busy=%b err=%b code=%0d cnt=%0d in=%h en=%b expected 1 1 0 0 0 4 44 0000",
               tag, ff_en, rdy, busy, err, err_code, frame_cnt, configs_in, configs_en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) step();
    n_checks++;
    if ({configs_in, configs_en, cfg_ready, ff_en, rdy, busy, err, err_code, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: outputs=%h expected 0",
               {configs_in, configs_en, cfg_ready, ff_en, rdy, busy, err, err_code, frame_cnt});
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({configs_in, configs_en, cfg_ready, ff_en, rdy, busy, err, err_code, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: outputs=%h expected 0",
               {configs_in, configs_en, cfg_ready, ff_en, rdy, busy, err, err_code, frame_cnt});
    end
    // Frames offered in IDLE must be ignored.
    cfg_valid = 1'b1;
    cfg_data  = 8'h5A;
    step();
    step();
    n_checks++;
    if (configs_en !== 4'b0000 || frame_cnt !== 3'd0 || configs_in !== 8'h00 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_valid_ignored: en=%b cnt=%0d in=%h ready=%b expected 0000 0 00 0",
               configs_en, frame_cnt, configs_in, cfg_ready);
    end
    idle_inputs();
  endtask

  task automatic test_nominal();
    run_load(1'b0, "nominal");
  endtask

  // Issued from RUN, so this also covers reconfiguration of a running fabric.
  task automatic test_throttled();
    run_load(1'b1, "throttled");
  endtask

  task automatic test_short();
    int cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (cfg_ready !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = frames[i];
      cfg_last  = (i == 2);
      step();
    end
    n_checks++;
    if (configs_en !== 4'b0100 || frame_cnt !== 3'd3 || configs_in !== 8'h33) begin
      n_fail++;
      $display("FAIL short_strobe: en=%b cnt=%0d in=%h expected 0100 3 33", configs_en, frame_cnt, configs_in);
    end
    // Keep offering a frame: ERROR must not accept it.
    cfg_last = 1'b0;
    cfg_data = 8'h55;
    step();
    n_checks++;
    if ({err, err_code, ff_en, rdy, configs_en, cfg_ready, busy} !== 11'b1_01_0_0_0000_0_0 ||
        configs_in !== 8'h33 || frame_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL short_error: err=%b code=%0d ff_en=%b rdy=%b en=%b ready=%b busy=%b in=%h cnt=%0d expected 1 1 0 0 0000 0 0 33 3",
               err, err_code, ff_en, rdy, configs_en, cfg_ready, busy, configs_in, frame_cnt);
    end
    idle_inputs();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (err !== 1'b0 || err_code !== 2'd0 || frame_cnt !== 3'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL short_clear: err=%b code=%0d cnt=%0d busy=%b expected 0 0 0 1", err, err_code, frame_cnt, busy);
    end
  endtask

  // Continues the load started at the end of test_short.
  task automatic test_long();
    int   cyc;
    logic en_any;
    cyc = 0;
    while (cfg_ready !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    for (int i = 0; i < NF; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = frames[i];
      cfg_last  = 1'b0;
      step();
    end
    n_checks++;
    if (configs_en !== 4'b1000 || frame_cnt !== 3'd4 || configs_in !== 8'h44) begin
      n_fail++;
      $display("FAIL long_strobe: en=%b cnt=%0d in=%h expected 1000 4 44", configs_en, frame_cnt, configs_in);
    end
    step();
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || configs_en !== 4'b0000) begin
      n_fail++;
      $display("FAIL long_error: err=%b code=%0d en=%b expected 1 2 0000", err, err_code, configs_en);
    end
    idle_inputs();
    en_any = 1'b0;
    repeat (SET + RD + 2) begin
      step();
      if (ff_en !== 1'b0 || rdy !== 1'b0) en_any = 1'b1;
    end
    n_checks++;
    if (en_any !== 1'b0 || frame_cnt !== 3'd4 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL long_no_enable: ff_en/rdy_seen=%b cnt=%0d err=%b expected 0 4 1", en_any, frame_cnt, err);
    end
  endtask

  task automatic test_reconfig_reset();
    int cyc;
    run_load(1'b0, "from_error");
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (cfg_ready !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    for (int i = 0; i < 2; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = frames[i];
      cfg_last  = 1'b0;
      step();
    end
    cfg_valid = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (frame_cnt !== 3'd2 || cfg_ready !== 1'b1 || configs_en !== 4'b0000) begin
      n_fail++;
      $display("FAIL start_ignored_in_load: cnt=%0d ready=%b en=%b expected 2 1 0000", frame_cnt, cfg_ready, configs_en);
    end
    rst       = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = frames[2];
    step();
    n_checks++;
    if ({configs_in, configs_en, cfg_ready, ff_en, rdy, busy, err, err_code, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: outputs=%h expected 0",
               {configs_in, configs_en, cfg_ready, ff_en, rdy, busy, err, err_code, frame_cnt});
    end
    rst = 1'b0;
    idle_inputs();
    step();
    run_load(1'b0, "after_reset");
  endtask

  initial begin
    frames[0] = 8'h11;
    frames[1] = 8'h22;
    frames[2] = 8'h33;
    frames[3] = 8'h44;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_nominal();
    test_throttled();
    test_short();
    test_long();
    test_reconfig_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
